// File: rtl/thermo_pkg.sv
// Shared types and widths for the thermometer count bus (encoder and decoder sides).
package thermo_pkg;

  localparam int THERMO_W = 16;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } thermo_state_e;

endpackage

// File: rtl/thermo_code_check.sv
// Combinational classifier: thermometer code -> popcount and legal / bubble / range flags.
module thermo_code_check
  import thermo_pkg::*;
#(
  parameter int MAX_COUNT = 9
) (
  input  logic [THERMO_W-1:0] code,
  output logic [CNT_W-1:0]    k,
  output logic                is_legal,
  output logic                is_bubble,
  output logic                is_range
);

  localparam int PW = $clog2(THERMO_W + 1);

  logic [PW-1:0]     ones;
  logic [THERMO_W:0] code_ext;
  logic [THERMO_W:0] code_plus1;
  logic              contig;

  always_comb begin
    ones = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      ones = ones + PW'(code[i]);
    end
  end

  // A code of the form 2^k-1 shares no set bit with its successor.
  assign code_ext   = {1'b0, code};
  assign code_plus1 = code_ext + 1'b1;
  assign contig     = (code_ext & code_plus1) == '0;

  assign k         = ones[CNT_W-1:0];
  assign is_legal  = contig && (ones <= PW'(MAX_COUNT));
  assign is_range  = contig && (ones > PW'(MAX_COUNT));
  assign is_bubble = !contig;

endmodule

// File: rtl/thermo_count_decoder.sv
// Receive side of the thermometer count bus: synchronise, qualify over several samples, decode.
module thermo_count_decoder
  import thermo_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_SAMPLES = 3,
  parameter int MAX_COUNT      = 9
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic [THERMO_W-1:0] thermo_in,
  output logic [CNT_W-1:0]    count,
  output logic                count_valid,
  output logic                update_p,
  output logic                bubble_err,
  output logic                range_err
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_SAMPLES - 1);

  logic [SYNC_STAGES-1:0][THERMO_W-1:0] sync_reg;
  logic [THERMO_W-1:0] s_code;
  logic [THERMO_W-1:0] samp_reg;
  logic [3:0]          stab_reg, stab_next;
  thermo_state_e       state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                valid_reg, valid_next;
  logic                bub_reg, bub_next;
  logic                rng_reg, rng_next;
  logic                upd_reg, upd_next;
  // Set once any count has been qualified since reset; a relock to an
  // unchanged value after a glitch must not pulse update_p.
  logic                ever_reg, ever_next;
  logic                same, qualified;
  logic [CNT_W-1:0]    k;
  logic                is_legal, is_bubble, is_range;

  assign s_code = sync_reg[SYNC_STAGES-1];

  thermo_code_check #(
    .MAX_COUNT(MAX_COUNT)
  ) u_check (
    .code      (s_code),
    .k         (k),
    .is_legal  (is_legal),
    .is_bubble (is_bubble),
    .is_range  (is_range)
  );

  always_comb begin
    same = (s_code == samp_reg);
    if (!same) begin
      stab_next = '0;
    end else if (stab_reg == STAB_MAX) begin
      stab_next = stab_reg;
    end else begin
      stab_next = stab_reg + 4'd1;
    end
    qualified = (STABLE_SAMPLES == 1) || (same && (stab_next == STAB_MAX));
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    valid_next = valid_reg;
    bub_next   = bub_reg;
    rng_next   = rng_reg;
    ever_next  = ever_reg;
    upd_next   = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (qualified) begin
          if (is_legal) begin
            state_next = LOCKED;
            count_next = k;
            valid_next = 1'b1;
            bub_next   = 1'b0;
            rng_next   = 1'b0;
            ever_next  = 1'b1;
            upd_next   = !ever_reg || (k != count_reg);
          end else begin
            state_next = FAULT;
            bub_next   = bub_reg | is_bubble;
            rng_next   = rng_reg | is_range;
          end
        end
      end
      LOCKED: begin
        if (!same) begin
          state_next = SEARCH;
          valid_next = 1'b0;
        end
      end
      FAULT: begin
        if (!same) begin
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      samp_reg  <= '0;
      stab_reg  <= '0;
      state_reg <= SEARCH;
      count_reg <= '0;
      valid_reg <= 1'b0;
      bub_reg   <= 1'b0;
      rng_reg   <= 1'b0;
      upd_reg   <= 1'b0;
      ever_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], thermo_in};
      upd_reg  <= clk_en & upd_next;
      if (clk_en) begin
        samp_reg  <= s_code;
        stab_reg  <= stab_next;
        state_reg <= state_next;
        count_reg <= count_next;
        valid_reg <= valid_next;
        bub_reg   <= bub_next;
        rng_reg   <= rng_next;
        ever_reg  <= ever_next;
      end
    end
  end

  assign count       = count_reg;
  assign count_valid = valid_reg;
  assign update_p    = upd_reg;
  assign bubble_err  = bub_reg;
  assign range_err   = rng_reg;

endmodule

// File: tb/tb_thermo_count_decoder.sv
// Randomised and directed bench for thermo_count_decoder against a sample-level reference model.
module tb_thermo_count_decoder;
  import thermo_pkg::*;

  localparam int S = 3;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] thermo_in = 16'h001F;
  logic [3:0]  count;
  logic        count_valid, update_p, bubble_err, range_err;

  always #5 sys_clk = ~sys_clk;

  thermo_count_decoder #(
    .SYNC_STAGES(2),
    .STABLE_SAMPLES(S),
    .MAX_COUNT(9)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .thermo_in   (thermo_in),
    .count       (count),
    .count_valid (count_valid),
    .update_p    (update_p),
    .bubble_err  (bubble_err),
    .range_err   (range_err)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_samples = 0;

  // Reference model: history of sampled codes plus the externally visible outputs.
  logic [15:0] hist[$];
  logic [3:0]  m_count;
  bit          m_valid, m_fault, m_ever, m_bub, m_rng, m_upd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(16'h0000);
    m_count = 0;
    m_valid = 0;
    m_fault = 0;
    m_ever  = 0;
    m_bub   = 0;
    m_rng   = 0;
    m_upd   = 0;
  endtask

  function automatic bit last_s_equal();
    if (hist.size() < S) return 0;
    for (int i = 1; i < S; i++)
      if (hist[hist.size()-1-i] != hist[hist.size()-1]) return 0;
    return 1;
  endfunction

  task automatic model_step(input logic [15:0] c);
    int k;
    bit changed, qual, contig;
    hist.push_back(c);
    while (hist.size() > S + 1) void'(hist.pop_front());
    changed = hist[hist.size()-1] != hist[hist.size()-2];
    qual    = last_s_equal();
    k       = $countones(c);
    contig  = (c == 16'((32'd1 << k) - 1));
    m_upd   = 0;
    if (!m_valid && !m_fault) begin
      if (qual) begin
        if (contig && k <= 9) begin
          m_upd   = !m_ever || (4'(k) != m_count);
          m_count = 4'(k);
          m_valid = 1;
          m_ever  = 1;
          m_bub   = 0;
          m_rng   = 0;
        end else begin
          m_fault = 1;
          if (contig) m_rng = 1;
          else m_bub = 1;
        end
      end
    end else if (changed) begin
      m_valid = 0;
      m_fault = 0;
    end
  endtask

  task automatic compare_all();
    check("count", count, m_count);
    check("count_valid", count_valid, m_valid);
    check("update_p", update_p, m_upd);
    check("bubble_err", bubble_err, m_bub);
    check("range_err", range_err, m_rng);
  endtask

  // Called at a falling edge: apply code, idle gap cycles, then one clk_en sample.
  task automatic do_sample(input logic [15:0] code, input int gap);
    thermo_in = code;
    for (int i = 0; i < gap; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (i == 0) check("update_p_idle", update_p, 0);
    end
    clk_en = 1'b1;
    @(posedge sys_clk);
    model_step(code);
    @(negedge sys_clk);
    clk_en = 1'b0;
    n_samples++;
    $display("sample %0d code=%h count=%0d valid=%b upd=%b bub=%b rng=%b",
             n_samples, code, count, count_valid, update_p, bubble_err, range_err);
    compare_all();
  endtask

  task automatic hold(input logic [15:0] code, input int n);
    for (int i = 0; i < n; i++) do_sample(code, 3);
  endtask

  initial begin
    logic [15:0] code;
    int kind, kk;
    model_reset();
    repeat (3) @(negedge sys_clk);
    compare_all();
    rst_n = 1'b1;

    hold(16'h001F, 3);
    check("dir_lock5", count, 5);
    check("dir_lock5_valid", count_valid, 1);
    hold(16'h01FF, 3);
    check("dir_step9", count, 9);
    hold(16'h001F, 3);
    do_sample(16'h003F, 3);
    hold(16'h001F, 3);
    check("dir_glitch_cnt", count, 5);
    check("dir_glitch_upd", update_p, 0);
    hold(16'h0035, 3);
    check("dir_bubble", bubble_err, 1);
    check("dir_bubble_cnt", count, 5);
    hold(16'h0007, 3);
    check("dir_bub_clear", bubble_err, 0);
    check("dir_cnt3", count, 3);
    hold(16'h07FF, 3);
    check("dir_range", range_err, 1);
    hold(16'h0000, 3);
    check("dir_cnt0_valid", count_valid, 1);
    hold(16'h0007, 3);
    hold(16'h00FF, 2);

    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("dir_rst_cnt", count, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    hold(16'h00FF, 2);
    check("dir_rst_not_yet", count_valid, 0);
    do_sample(16'h00FF, 3);
    check("dir_rst_cnt8", count, 8);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        kk = $urandom_range(0, 9);
        code = 16'((32'd1 << kk) - 1);
      end else if (kind == 2) begin
        kk = $urandom_range(10, 16);
        code = 16'((32'd1 << kk) - 1);
      end else begin
        code = 16'($urandom);
      end
      for (int j = 0, n = $urandom_range(1, 4); j < n; j++)
        do_sample(code, $urandom_range(2, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
